sha256_stream_hasher: RTL and testbench

Parametrised successor to the fixed 20-word SHA-256 engine. Hashes a word-aligned message of runtime length `msg_words` (0..MAX_WORDS) read from the shared single-port memory. Padding is generated on the fly, so there is no message buffer, and any number of blocks is handled. The engine computes one round per cycle using a 16-entry sliding schedule window, then writes the 8-word digest back to memory and exposes it on a port.

---
 rtl/sha256_pkg.sv | 97 +++++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256_stream_hasher.sv | 175 +++++++++++++++++
 tb/tb_sha256_stream_hasher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type, working-variable struct and the round/schedule helper functions.
// Shared by the streaming hasher top and its combinational round sub-module.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, PREP, ROUND, FINAL, WRITE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Padded length is N words + 0x80 marker + 2 length words, rounded up to whole blocks.
    function automatic int blocks_for(input int n);
        return (n + 2) / 16 + 1;
    endfunction

    function automatic work_t iv_state();
        return {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
    endfunction

    function automatic work_t add_state(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

    function automatic logic [31:0] state_word(input work_t s, input logic [2:0] k);
        case (k)
            3'd0:    return s.a;
            3'd1:    return s.b;
            3'd2:    return s.c;
            3'd3:    return s.d;
            3'd4:    return s.e;
            3'd5:    return s.f;
            3'd6:    return s.g;
            default: return s.h;
        endcase
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational: {a..h}, W_t, K_t in, next {a..h} out.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_stream_hasher.sv
// Streams a word-aligned message from memory, pads on the fly and hashes it one round per cycle.
// Start to done: 66 cycles per 512-bit block plus 8 digest write cycles; no overlap between hashes.
module sha256_stream_hasher
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [LEN_W-1:0]  msg_words,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [255:0]      digest
);

    localparam int BLK_W = $clog2(blocks_for(MAX_WORDS) + 1);
    localparam int IDX_W = BLK_W + 4;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] out_addr;
    logic [LEN_W-1:0]  n_words;
    logic [LEN_W-1:0]  len_sat;
    logic [BLK_W-1:0]  blk;
    logic [BLK_W-1:0]  n_blocks;
    logic [5:0]        rnd;
    logic [2:0]        wk;
    work_t             hash;
    work_t             work;
    work_t             round_out;
    work_t             hash_sum;
    logic [31:0]       win [16];
    logic [31:0]       w_t;
    logic [IDX_W-1:0]  cur_idx;
    logic              last_blk;

    function automatic logic is_msg(input logic [IDX_W-1:0] idx, input logic [LEN_W-1:0] n);
        return 32'(idx) < 32'(n);
    endfunction

    function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base, input logic [IDX_W-1:0] idx);
        return base + ADDR_W'(idx);
    endfunction

    assign mem_clk  = clk;
    assign done     = (state == IDLE);
    assign len_sat  = (msg_words > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : msg_words;
    assign last_blk = (blk == n_blocks - BLK_W'(1));
    assign cur_idx  = {blk, rnd[3:0]};
    assign hash_sum = add_state(hash, work);

    // First 16 rounds take the padded stream; later rounds expand from the sliding window.
    always_comb begin
        w_t = '0;
        if (rnd < 6'd16) begin
            if (is_msg(cur_idx, n_words)) begin
                w_t = mem_read_data;
            end else if (32'(cur_idx) == 32'(n_words)) begin
                w_t = 32'h80000000;
            end else if (last_blk && rnd[3:0] == 4'hf) begin
                w_t = 32'(n_words) << 5;
            end
        end else begin
            w_t = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
        end
    end

    sha256_round u_round (
        .cur (work),
        .w   (w_t),
        .k   (K[rnd]),
        .nxt (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = ROUND;
            ROUND:   if (rnd == 6'd63) state_next = FINAL;
            FINAL:   state_next = last_blk ? WRITE : PREP;
            WRITE:   if (wk == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr      <= '0;
            out_addr       <= '0;
            n_words        <= '0;
            n_blocks       <= '0;
            blk            <= '0;
            rnd            <= '0;
            wk             <= '0;
            hash           <= '0;
            work           <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            digest         <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr <= message_addr;
                        out_addr  <= output_addr;
                        n_words   <= len_sat;
                        n_blocks  <= BLK_W'(blocks_for(int'(len_sat)));
                        blk       <= '0;
                        rnd       <= '0;
                        wk        <= '0;
                        hash      <= iv_state();
                        work      <= iv_state();
                        if (len_sat != '0) mem_addr <= message_addr;
                    end
                end
                PREP: begin
                    if (is_msg({blk, 4'd1}, n_words)) mem_addr <= rd_addr(base_addr, {blk, 4'd1});
                end
                ROUND: begin
                    work <= round_out;
                    rnd  <= rnd + 6'd1;
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_t;
                    // Address issued now is consumed two rounds ahead (one cycle register, one cycle memory).
                    if (rnd < 6'd14 && is_msg({blk, rnd[3:0] + 4'd2}, n_words))
                        mem_addr <= rd_addr(base_addr, {blk, rnd[3:0] + 4'd2});
                end
                FINAL: begin
                    hash <= hash_sum;
                    work <= hash_sum;
                    if (!last_blk) begin
                        blk <= blk + BLK_W'(1);
                        if (is_msg({blk + BLK_W'(1), 4'd0}, n_words))
                            mem_addr <= rd_addr(base_addr, {blk + BLK_W'(1), 4'd0});
                    end else begin
                        digest         <= hash_sum;
                        wk             <= '0;
                        mem_we         <= 1'b1;
                        mem_addr       <= out_addr;
                        mem_write_data <= state_word(hash_sum, 3'd0);
                    end
                end
                WRITE: begin
                    if (wk == 3'd7) begin
                        mem_we <= 1'b0;
                    end else begin
                        wk             <= wk + 3'd1;
                        mem_addr       <= out_addr + ADDR_W'(wk + 3'd1);
                        mem_write_data <= state_word(hash, wk + 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Randomised scoreboard bench for sha256_stream_hasher against a textbook SHA-256 model.
module tb_sha256_stream_hasher;

    localparam int MAXW = 1024;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] dig;
        logic [15:0]  oaddr;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [15:0]  message_addr;
    logic [15:0]  output_addr;
    logic [10:0]  msg_words;
    logic         done;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic [255:0] digest;

    logic [31:0]  mem [0:65535];
    exp_t         exp_q [$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           write_cnt = 0;
    logic [255:0] last_dig = '0;

    sha256_stream_hasher dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .msg_words      (msg_words),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .digest         (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_addr];

    function automatic logic [31:0] rr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [255:0] ref_hash(input logic [15:0] base, input int n);
        logic [31:0] pad [$];
        logic [31:0] hs [8];
        logic [31:0] w [64];
        logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
        int nb;
        nb = (n + 3 + 15) / 16;
        for (int i = 0; i < 16 * nb; i++) begin
            if (i < n)                pad.push_back(mem[base + 16'(i)]);
            else if (i == n)          pad.push_back(32'h80000000);
            else if (i == 16*nb - 1)  pad.push_back(32'(n * 32));
            else                      pad.push_back(32'h0);
        end
        hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = pad[16*b + t];
                else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                          + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            va = hs[0]; vb = hs[1]; vc = hs[2]; vd = hs[3];
            ve = hs[4]; vf = hs[5]; vg = hs[6]; vh = hs[7];
            for (int t = 0; t < 64; t++) begin
                t1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[t] + w[t];
                t2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
                vh = vg; vg = vf; vf = ve; ve = vd + t1;
                vd = vc; vc = vb; vb = va; va = t1 + t2;
            end
            hs[0] += va; hs[1] += vb; hs[2] += vc; hs[3] += vd;
            hs[4] += ve; hs[5] += vf; hs[6] += vg; hs[7] += vh;
        end
        return {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write beat is matched against the head of the scoreboard.
    initial begin
        int wr_k;
        logic [255:0] d;
        wr_k = 0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_addr, mem_write_data);
                end else begin
                    d = exp_q[0].dig;
                    chk("write_addr", 256'(mem_addr), 256'(exp_q[0].oaddr + 16'(wr_k)));
                    chk("write_data", 256'(mem_write_data), 256'(d[255 - 32*wr_k -: 32]));
                    wr_k++;
                    if (wr_k == 8) begin
                        chk("digest_port", digest, d);
                        void'(exp_q.pop_front());
                        wr_k = 0;
                    end
                end
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge where done rises.
    task automatic run_hash(input logic [15:0] base, input logic [15:0] oaddr, input int n_in,
                            input logic [255:0] fixed, input bit use_fixed, input int repulse);
        int n_eff, lat, cyc;
        exp_t e;
        n_eff = (n_in > MAXW) ? MAXW : n_in;
        lat = 66 * ((n_eff + 3 + 15) / 16) + 8;
        e.dig = use_fixed ? fixed : ref_hash(base, n_eff);
        e.oaddr = oaddr;
        exp_q.push_back(e);
        start = 1'b1;
        message_addr = base;
        output_addr = oaddr;
        msg_words = 11'(n_in);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            if (repulse != 0 && cyc == repulse) begin
                start = 1'b1;
                message_addr = ~base;
                output_addr = oaddr + 16'h0100;
                msg_words = 11'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", 256'(cyc), 256'(lat));
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
        last_dig = e.dig;
    endtask

    initial begin
        int wc0;
        reset = 1'b1;
        start = 1'b0;
        message_addr = '0;
        output_addr = '0;
        msg_words = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom();
        mem[16'h0200] = 32'h61626364;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 256'(done), 256'(1));
        chk("reset_mem_we", 256'(mem_we), 256'(0));
        chk("reset_mem_addr", 256'(mem_addr), 256'(0));
        chk("reset_wdata", 256'(mem_write_data), 256'(0));
        chk("reset_digest", digest, 256'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 256'(done), 256'(1));

        run_hash(16'h0100, 16'h2000, 0,
                 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1'b1, 0);
        run_hash(16'h0200, 16'h2010, 1,
                 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589, 1'b1, 0);

        wc0 = write_cnt;
        run_hash(16'h0300, 16'h2020, 20, '0, 1'b0, 0);
        chk("write_count_20", 256'(write_cnt - wc0), 256'(8));
        run_hash(16'h0400, 16'h2030, 13, '0, 1'b0, 0);
        run_hash(16'h0500, 16'h2040, 14, '0, 1'b0, 0);

        // Abort in round 30 of the first block of a 20-word hash.
        wc0 = write_cnt;
        start = 1'b1;
        message_addr = 16'h0300;
        output_addr = 16'h5000;
        msg_words = 11'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_done", 256'(done), 256'(1));
        chk("abort_mem_we", 256'(mem_we), 256'(0));
        chk("abort_digest", digest, 256'(0));
        repeat (150) @(posedge clk);
        #1;
        chk("abort_still_idle", 256'(done), 256'(1));
        chk("abort_no_writes", 256'(write_cnt - wc0), 256'(0));
        chk("abort_digest_held", digest, 256'(0));
        run_hash(16'h0300, 16'h5000, 20, '0, 1'b0, 0);

        run_hash(16'hfff8, 16'h6000, 30, '0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            run_hash(16'($urandom()), 16'h7000 + 16'(i * 16), int'($urandom_range(0, 48)), '0, 1'b0, 0);
        end

        run_hash(16'h8000, 16'h3000, MAXW + 5, '0, 1'b0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
